wb_burst_master: RTL
====================

# wb_burst_master

Wishbone B3 initiator that turns single-word commands into linear incrementing bursts of 1–16 beats on a 32-bit Wishbone bus. It sits on an arbiter master port beside the CPU and debug masters. Its first uses are main-RAM fill and test traffic, and the exerciser for B3 registered-feedback slaves. Write data arrives on a valid/ready stream; read data leaves on a valid-only stream; a done pulse reports completion status.

## Interface
- TIMEOUT, default 255: maximum number of cycles with stb asserted and no ack/err/rty before the burst is aborted with error. 0 disables the check.
- wb_clk_i  in  1  clock; all logic on its rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block idle, command accepted when valid&ready.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  32  start byte address; bits [1:0] ignored (forced 0).
- cmd_len_i  in  4  beats minus one (0 → 1 beat, 15 → 16 beats).
- wr_dat_i  in  32  write data.
- wr_valid_i  in  1  write data present.
- wr_ready_o  out  1  write word consumed when valid&ready.
- rd_dat_o  out  32  read data, registered.
- rd_valid_o  out  1  one-cycle pulse per read beat.
- done_o  out  1  one-cycle pulse at end of every command.
- done_err_o  out  1  qualifies done_o; 1 = command terminated by err, rty or timeout.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  constant 4'hF.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  cycle type identifier.
- wb_bte_o  out  2  constant 2'b00 (linear).
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry.

## Operation
- States: IDLE, LOAD (write only, waiting for data), BUS.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch adr={cmd_adr_i[31:2],2'b00}, we and beats=cmd_len_i+1 (5-bit).
  - Read → BUS with cyc=stb=1.
  - Write → LOAD.
- LOAD:
  - wr_ready_o=1, cyc held as previously set, stb=0.
  - On wr_valid_i: wb_dat_o←wr_dat_i, cyc=stb=1, → BUS.
- BUS:
  - All Wishbone outputs are registered and stable until the termination.
  - Ack on a read beat: rd_dat_o←wb_dat_i and rd_valid_o=1 on the next cycle.
  - Every ack: adr += 4, wrapping modulo 2^32; beats -= 1.
- Write continuation (non-last ack):
  - wr_ready_o = wb_ack_i & ~last & we, combinational.
  - If wr_valid_i is high, load the next word and keep stb high (zero-wait burst).
  - Otherwise stb drops, cyc stays high, → LOAD.
- cti:
  - 3'b010 while beats>1.
  - 3'b111 on the last beat, including single-beat commands.
- Last ack: cyc=stb=0, done_o=1, done_err_o=0, → IDLE.
- wb_err_i or wb_rty_i while stb is high:
  - Abort: cyc=stb=0, done_o=1, done_err_o=1, → IDLE.
  - No further wr_ready_o for that command; unconsumed write words stay with the producer.
- Timeout:
  - A counter clears on every ack and on entry to BUS, and counts while stb=1.
  - Reaching TIMEOUT aborts exactly as for err.
- Simultaneous ack and err: err wins, the beat is not counted, and rd_valid_o is not asserted.

## Timing
- Reset values: cmd_ready_o=0 during reset, 1 the first cycle after; all other outputs 0, including wb_cyc_o/wb_stb_o, wb_cti_o=0, wb_adr_o=0.
- Reset mid-burst: cyc/stb are 0 on the cycle after the reset edge; no done_o is issued.
- Read command accepted at edge N: cyc/stb/adr/cti are valid from cycle N+1.
- Read beat acked at edge M: rd_valid_o high during cycle M+1.
- Final ack at edge M: cyc=0 and done_o=1 during M+1; next command accepted at edge M+1 at earliest.
- Write command: LOAD is entered at N+1; with wr_valid_i already high, stb rises at N+2.
- Back-to-back acks and continuous wr_valid_i give one beat per cycle.

## Test plan
- Read, len=3 from 0x100, slave acks every cycle: adr 0x100/0x104/0x108/0x10C; cti 010,010,010,111; four rd_valid pulses with the slave data; one done_o, done_err_o=0.
- Write, len=0 to 0x203 with data 0xDEADBEEF: adr=0x200, cti=111, sel=F, wb_dat_o=0xDEADBEEF; one wr_ready; done_o.
- Write, len=7 with wr_valid_i low for 2 cycles after beat 3: stb=0 for those cycles while cyc=1; all 8 words land in order in RAM; readback matches.
- Read, len=3, err on beat 2: cyc=0 on the next cycle; exactly one rd_valid pulse; done_o with done_err_o=1.
- TIMEOUT=8, slave never acks: abort exactly 8 cycles after stb rises; done_err_o=1.
- Start at 0xFFFFFFF8 with len=3: addresses wrap 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- wb_rst_i pulsed mid-burst: all outputs reset the next cycle; no done_o is issued.

Source files
------------

// File: rtl/wb_burst_master_if.sv
//------------------------------------------------------------------------------
// wb_burst_master_if
// Command, write-data, read-data, status and Wishbone B3 bus signals of the
// burst master, bundled with master (the block) and slave (its environment)
// views.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_burst_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [3:0]  cmd_len_i;
    logic [31:0] wr_dat_i;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [31:0] rd_dat_o;
    logic        rd_valid_o;
    logic        done_o;
    logic        done_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
        input  wr_dat_i, wr_valid_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output cmd_ready_o, wr_ready_o, rd_dat_o, rd_valid_o, done_o, done_err_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_cti_o, wb_bte_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_len_i,
        output wr_dat_i, wr_valid_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  cmd_ready_o, wr_ready_o, rd_dat_o, rd_valid_o, done_o, done_err_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_cti_o, wb_bte_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_burst_master.sv
//------------------------------------------------------------------------------
// wb_burst_master
// Wishbone B3 initiator: turns one command into a linear incrementing burst of
// 1-16 beats, with a write-data stream in and a read-data stream out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_burst_master #(
    parameter int TIMEOUT = 255
) (
    input  wire logic            wb_clk_i,
    input  wire logic            wb_rst_i,
    wb_burst_master_if.master    bus
);

    localparam logic [2:0] c_CTI_INCR = 3'b010;
    localparam logic [2:0] c_CTI_END  = 3'b111;
    localparam int         c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit         c_TMO_EN   = (TIMEOUT != 0);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BUS  = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [31:0]        r_adr, w_adr;
    logic [31:0]        r_dat, w_dat;
    logic               r_we, w_we;
    logic               r_cyc, w_cyc;
    logic               r_stb, w_stb;
    logic [2:0]         r_cti, w_cti;
    logic [4:0]         r_beats, w_beats;
    logic [c_TMO_W-1:0] r_tmo, w_tmo;
    logic [31:0]        r_rd_dat, w_rd_dat;
    logic               r_rd_valid, w_rd_valid;
    logic               r_done, w_done;
    logic               r_done_err, w_done_err;
    logic               w_cmd_ready;
    logic               w_wr_ready;
    logic               w_last;
    logic               w_tmo_hit;
    logic               w_abort;
    logic               w_unused_adr;

    assign w_unused_adr = &{1'b0, bus.cmd_adr_i[1:0]};

    assign w_last    = (r_beats == 5'd1);
    // The final silent cycle counts toward the limit, so stb stays up exactly TIMEOUT cycles.
    assign w_tmo_hit = c_TMO_EN && (r_tmo == c_TMO_LAST) && !bus.wb_ack_i;
    assign w_abort   = bus.wb_err_i | bus.wb_rty_i | w_tmo_hit;

    always_comb begin
        w_state     = r_state;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_we        = r_we;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_cti       = r_cti;
        w_beats     = r_beats;
        w_tmo       = r_tmo;
        w_rd_dat    = r_rd_dat;
        w_rd_valid  = 1'b0;
        w_done      = 1'b0;
        w_done_err  = 1'b0;
        w_cmd_ready = 1'b0;
        w_wr_ready  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready = ~wb_rst_i;
                if (bus.cmd_valid_i) begin
                    w_adr   = {bus.cmd_adr_i[31:2], 2'b00};
                    w_we    = bus.cmd_we_i;
                    w_beats = {1'b0, bus.cmd_len_i} + 5'd1;
                    w_cti   = (bus.cmd_len_i == 4'd0) ? c_CTI_END : c_CTI_INCR;
                    w_tmo   = '0;
                    if (bus.cmd_we_i) begin
                        w_state = S_LOAD;
                    end else begin
                        w_cyc   = 1'b1;
                        w_stb   = 1'b1;
                        w_state = S_BUS;
                    end
                end
            end

            S_LOAD: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid_i) begin
                    w_dat   = bus.wr_dat_i;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_tmo   = '0;
                    w_state = S_BUS;
                end
            end

            S_BUS: begin
                // err/rty override a simultaneous ack: the beat is dropped entirely.
                if (w_abort) begin
                    w_cyc      = 1'b0;
                    w_stb      = 1'b0;
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                    w_state    = S_IDLE;
                end else if (bus.wb_ack_i) begin
                    w_adr   = r_adr + 32'd4;
                    w_beats = r_beats - 5'd1;
                    w_tmo   = '0;
                    if (!r_we) begin
                        w_rd_dat   = bus.wb_dat_i;
                        w_rd_valid = 1'b1;
                    end
                    if (w_last) begin
                        w_cyc   = 1'b0;
                        w_stb   = 1'b0;
                        w_done  = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_cti = (r_beats == 5'd2) ? c_CTI_END : c_CTI_INCR;
                        if (r_we) begin
                            w_wr_ready = 1'b1;
                            if (bus.wr_valid_i) begin
                                w_dat = bus.wr_dat_i;
                            end else begin
                                w_stb   = 1'b0;
                                w_state = S_LOAD;
                            end
                        end
                    end
                end else if (c_TMO_EN) begin
                    w_tmo = r_tmo + c_TMO_ONE;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_adr      <= '0;
            r_dat      <= '0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_cti      <= 3'b000;
            r_beats    <= '0;
            r_tmo      <= '0;
            r_rd_dat   <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_adr      <= w_adr;
            r_dat      <= w_dat;
            r_we       <= w_we;
            r_cyc      <= w_cyc;
            r_stb      <= w_stb;
            r_cti      <= w_cti;
            r_beats    <= w_beats;
            r_tmo      <= w_tmo;
            r_rd_dat   <= w_rd_dat;
            r_rd_valid <= w_rd_valid;
            r_done     <= w_done;
            r_done_err <= w_done_err;
        end
    end

    assign bus.cmd_ready_o = w_cmd_ready;
    assign bus.wr_ready_o  = w_wr_ready;
    assign bus.rd_dat_o    = r_rd_dat;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.done_o      = r_done;
    assign bus.done_err_o  = r_done_err;
    assign bus.wb_adr_o    = r_adr;
    assign bus.wb_dat_o    = r_dat;
    assign bus.wb_sel_o    = 4'hF;
    assign bus.wb_we_o     = r_we;
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_stb_o    = r_stb;
    assign bus.wb_cti_o    = r_cti;
    assign bus.wb_bte_o    = 2'b00;

endmodule

`default_nettype wire
